// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Bundles the two register-file write requesters, the
//               pending-write scoreboard check and the register-file write
//               port into one connection for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if;
    // Requester A: pipeline writeback
    logic        a_wena;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    // Requester B: long-latency writeback (valid/ready)
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    // Scoreboard issue / check
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard;
    logic        stall_req;
    // Register-file write port
    logic        rf_wena;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_cnt;

    // Pipeline / long-latency side
    modport master (
        output a_wena, a_waddr, a_wdata,
        output b_valid, b_waddr, b_wdata,
        output iss_valid, iss_addr, chk_addr1, chk_addr2,
        input  b_ready, hazard, stall_req,
        input  rf_wena, rf_waddr, rf_wdata, fifo_cnt
    );

    // Arbiter side
    modport slave (
        input  a_wena, a_waddr, a_wdata,
        input  b_valid, b_waddr, b_wdata,
        input  iss_valid, iss_addr, chk_addr1, chk_addr2,
        output b_ready, hazard, stall_req,
        output rf_wena, rf_waddr, rf_wdata, fifo_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the single register-file write port between the
//               pipeline writeback (fixed priority) and a 2-entry buffered
//               long-latency writeback, tracks pending long-latency
//               destinations for RAW detection, and requests pipeline stalls
//               so buffered results cannot starve.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rf_write_arbiter_if.slave  bus
);

    localparam logic [3:0] c_AGE_MAX   = 4'd15;
    localparam logic [3:0] c_AGE_LIMIT = 4'(STARVE_MAX - 1);

    // B buffer storage and control
    logic [4:0]  r_mem_addr [2];
    logic [31:0] r_mem_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_cnt;
    logic [3:0]  r_age;
    logic [31:0] r_pending;

    // Registered write port
    logic        r_rf_wena;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic        w_b_ready;
    logic        w_accept;
    logic        w_push;
    logic        w_a_sel;
    logic        w_pop;
    logic [4:0]  w_head_addr;
    logic [31:0] w_head_data;
    logic [1:0]  w_cnt_nxt;
    logic [31:0] w_pending_nxt;

    // Room is judged on the registered count only, so a same-cycle pop
    // never lets a third result in.
    assign w_b_ready   = !rst && (r_cnt != 2'd2);
    assign w_accept    = bus.b_valid && w_b_ready;
    // Handshakes to x0 complete but are never buffered.
    assign w_push      = w_accept && (bus.b_waddr != 5'd0);
    assign w_a_sel     = bus.a_wena && (bus.a_waddr != 5'd0);
    assign w_pop       = !w_a_sel && (r_cnt != 2'd0);
    assign w_head_addr = r_mem_addr[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // Occupancy update from this cycle's push and pop
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Scoreboard update: clear on drain first, so a same-cycle issue wins
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
            w_pending_nxt[bus.iss_addr] = 1'b1;
        end
    end

    // Two-entry FIFO holding accepted B results in acceptance order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= bus.b_waddr;
                r_mem_data[r_wr_ptr] <= bus.b_wdata;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    // Pending-write bits for issued B destinations
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Saturating count of cycles the buffer head has waited without draining
    always_ff @(posedge clk) begin
        if (rst || (r_cnt == 2'd0) || w_pop) begin
            r_age <= 4'd0;
        end else if (r_age != c_AGE_MAX) begin
            r_age <= r_age + 4'd1;
        end
    end

    // Write-port arbitration: A first, then buffer head; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wena  <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else if (w_a_sel) begin
            r_rf_wena  <= 1'b1;
            r_rf_waddr <= bus.a_waddr;
            r_rf_wdata <= bus.a_wdata;
        end else if (w_pop) begin
            r_rf_wena  <= 1'b1;
            r_rf_waddr <= w_head_addr;
            r_rf_wdata <= w_head_data;
        end else begin
            r_rf_wena  <= 1'b0;
        end
    end

    assign bus.b_ready   = w_b_ready;
    assign bus.hazard    = !rst && (r_pending[bus.chk_addr1] | r_pending[bus.chk_addr2]);
    // Age only rises while something is buffered; the occupancy term keeps
    // STARVE_MAX=1 from stalling an empty buffer.
    assign bus.stall_req = !rst && ((r_cnt == 2'd2) ||
                                    ((r_cnt != 2'd0) && (r_age >= c_AGE_LIMIT)));
    assign bus.rf_wena   = r_rf_wena;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.fifo_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter: directed vector
//               table, hand-written multi-cycle sequences and randomized
//               traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;

    rf_write_arbiter_if ifc();

    rf_write_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: buffered results as a queue, pending bits, wait age
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_age;
    logic        m_wena;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    typedef struct {
        logic        aw;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e_wena;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_haz;
        logic        e_rdy;
        logic [1:0]  e_cnt;
        logic        e_stall;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model's view of the starvation condition, ignoring reset
    function automatic bit m_stall_cond();
        return (mq.size() == 2) || ((mq.size() > 0) && (m_age >= STARVE_MAX - 1));
    endfunction

    task automatic drive(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ia,
                         input logic [4:0] c1, input logic [4:0] c2, input logic r);
        rst           = r;
        ifc.a_wena    = aw;
        ifc.a_waddr   = aa;
        ifc.a_wdata   = ad;
        ifc.b_valid   = bv;
        ifc.b_waddr   = ba;
        ifc.b_wdata   = bd;
        ifc.iss_valid = iv;
        ifc.iss_addr  = ia;
        ifc.chk_addr1 = c1;
        ifc.chk_addr2 = c2;
        #2;
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, c1, c2, 1'b0);
    endtask

    // Compare every output with the model, advance the model, cross the edge
    task automatic step();
        bit   a_sel;
        bit   acc;
        bit   pop;
        int   sz0;
        ent_t e;
        checks++;
        assert (!(ifc.stall_req && ifc.a_wena)) else begin
            errors++;
            $display("FAIL contract: stall_req=1 with a_wena=1 at %0t", $time);
        end
        check("rf_wena",   32'(ifc.rf_wena),   32'(m_wena));
        check("rf_waddr",  32'(ifc.rf_waddr),  32'(m_waddr));
        check("rf_wdata",  ifc.rf_wdata,       m_wdata);
        check("b_ready",   32'(ifc.b_ready),   32'(!rst && mq.size() < 2));
        check("hazard",    32'(ifc.hazard),
              32'(!rst && (m_pend[ifc.chk_addr1] || m_pend[ifc.chk_addr2])));
        check("stall_req", 32'(ifc.stall_req), 32'(!rst && m_stall_cond()));
        check("fifo_cnt",  32'(ifc.fifo_cnt),  32'(mq.size()));

        if (rst) begin
            mq.delete();
            m_pend  = '0;
            m_age   = 0;
            m_wena  = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            sz0   = mq.size();
            a_sel = ifc.a_wena && (ifc.a_waddr != 0);
            acc   = ifc.b_valid && (sz0 < 2);
            pop   = !a_sel && (sz0 > 0);
            if (a_sel) begin
                m_wena  = 1'b1;
                m_waddr = ifc.a_waddr;
                m_wdata = ifc.a_wdata;
            end else if (pop) begin
                e       = mq.pop_front();
                m_wena  = 1'b1;
                m_waddr = e.addr;
                m_wdata = e.data;
                m_pend[e.addr] = 1'b0;
            end else begin
                m_wena = 1'b0;
            end
            if (sz0 == 0 || pop) m_age = 0;
            else if (m_age < 15) m_age = m_age + 1;
            if (acc && ifc.b_waddr != 0) mq.push_back('{addr: ifc.b_waddr, data: ifc.b_wdata});
            if (ifc.iss_valid && ifc.iss_addr != 0) m_pend[ifc.iss_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed table: inputs for one cycle and the outputs seen that cycle
        tbl[0] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                   1'b0, 5'd0, 32'd0,        1'b0, 1'b1, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                   1'b1, 5'd5, 32'h12345678, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0,
                   1'b0, 5'd5, 32'h12345678, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0,
                   1'b0, 5'd5, 32'h12345678, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE0001, 1'b0, 5'd0, 5'd9, 5'd0,
                   1'b0, 5'd5, 32'h12345678, 1'b1, 1'b1, 2'd0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0,
                   1'b0, 5'd5, 32'h12345678, 1'b1, 1'b1, 2'd1, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0,
                   1'b1, 5'd9, 32'hCAFE0001, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0,
                   1'b0, 5'd9, 32'hCAFE0001, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[8] = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 5'd0, 5'd0,
                   1'b0, 5'd9, 32'hCAFE0001, 1'b0, 1'b1, 2'd0, 1'b0};
        tbl[9] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                   1'b0, 5'd9, 32'hCAFE0001, 1'b0, 1'b1, 2'd0, 1'b0};

        // Reset
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_pend  = '0;
        m_age   = 0;
        m_wena  = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
        check("rst.rf_wena",   32'(ifc.rf_wena),   32'd0);
        check("rst.rf_waddr",  32'(ifc.rf_waddr),  32'd0);
        check("rst.rf_wdata",  ifc.rf_wdata,       32'd0);
        check("rst.b_ready",   32'(ifc.b_ready),   32'd0);
        check("rst.stall_req", 32'(ifc.stall_req), 32'd0);
        check("rst.fifo_cnt",  32'(ifc.fifo_cnt),  32'd0);
        step();

        // Directed table: A latency, scoreboard round trip, register-0 drops
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
                  tbl[i].iv, tbl[i].ia, tbl[i].c1, tbl[i].c2, 1'b0);
            check($sformatf("vec%0d.rf_wena", i),   32'(ifc.rf_wena),   32'(tbl[i].e_wena));
            check($sformatf("vec%0d.rf_waddr", i),  32'(ifc.rf_waddr),  32'(tbl[i].e_waddr));
            check($sformatf("vec%0d.rf_wdata", i),  ifc.rf_wdata,       tbl[i].e_wdata);
            check($sformatf("vec%0d.hazard", i),    32'(ifc.hazard),    32'(tbl[i].e_haz));
            check($sformatf("vec%0d.b_ready", i),   32'(ifc.b_ready),   32'(tbl[i].e_rdy));
            check($sformatf("vec%0d.fifo_cnt", i),  32'(ifc.fifo_cnt),  32'(tbl[i].e_cnt));
            check($sformatf("vec%0d.stall_req", i), 32'(ifc.stall_req), 32'(tbl[i].e_stall));
            step();
        end

        // Buffer fills behind continuous A traffic, then drains in order
        drive(1'b1, 5'd10, 32'h1010, 1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, 5'd11, 32'h1111, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        idle(5'd0, 5'd0);
        check("full.fifo_cnt",  32'(ifc.fifo_cnt),  32'd2);
        check("full.b_ready",   32'(ifc.b_ready),   32'd0);
        check("full.stall_req", 32'(ifc.stall_req), 32'd1);
        step();
        idle(5'd0, 5'd0);
        check("drain1.rf_wena",  32'(ifc.rf_wena),  32'd1);
        check("drain1.rf_waddr", 32'(ifc.rf_waddr), 32'd3);
        check("drain1.rf_wdata", ifc.rf_wdata,      32'hA);
        step();
        idle(5'd0, 5'd0);
        check("drain2.rf_wena",  32'(ifc.rf_wena),  32'd1);
        check("drain2.rf_waddr", 32'(ifc.rf_waddr), 32'd4);
        check("drain2.rf_wdata", ifc.rf_wdata,      32'hB);
        check("drain2.fifo_cnt", 32'(ifc.fifo_cnt), 32'd0);
        step();

        // Starvation: single entry waits behind A until stall_req
        drive(1'b1, 5'd12, 32'h1212, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 5'(12 + k), 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            check($sformatf("age%0d.stall_req", k), 32'(ifc.stall_req), 32'd0);
            check($sformatf("age%0d.fifo_cnt", k),  32'(ifc.fifo_cnt),  32'd1);
            step();
        end
        idle(5'd0, 5'd0);
        check("starve.stall_req", 32'(ifc.stall_req), 32'd1);
        step();
        idle(5'd0, 5'd0);
        check("starve.rf_waddr",  32'(ifc.rf_waddr),  32'd7);
        check("starve.rf_wdata",  ifc.rf_wdata,       32'h77);
        check("starve.stall_off", 32'(ifc.stall_req), 32'd0);
        step();

        // Reset with two buffered results and pending bits
        drive(1'b1, 5'd13, 32'h1313, 1'b1, 5'd20, 32'h2020, 1'b1, 5'd20, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, 5'd14, 32'h1414, 1'b1, 5'd21, 32'h2121, 1'b1, 5'd21, 5'd20, 5'd0, 1'b0);
        check("pre_rst.hazard", 32'(ifc.hazard), 32'd1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd21, 1'b1);
        check("in_rst.hazard",  32'(ifc.hazard),  32'd0);
        check("in_rst.b_ready", 32'(ifc.b_ready), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            idle(5'd20, 5'd21);
            check($sformatf("post_rst%0d.fifo_cnt", k), 32'(ifc.fifo_cnt), 32'd0);
            check($sformatf("post_rst%0d.hazard", k),   32'(ifc.hazard),   32'd0);
            check($sformatf("post_rst%0d.rf_wena", k),  32'(ifc.rf_wena),  32'd0);
            step();
        end

        // Randomized traffic honouring the stall contract
        for (int n = 0; n < 600; n++) begin
            logic r;
            logic aw;
            r  = ($urandom_range(0, 79) == 0);
            aw = ($urandom_range(0, 2) != 0) && !m_stall_cond();
            drive(aw, 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
